mc_move_validator: RTL

MC_MOVE_VALIDATOR -- requirements
Module: mc_move_validator

---
 rtl/mc_move_validator.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mc_move_validator.sv
// mc_move_validator: checks a missionaries/cannibals solver's bank states move by move and counts solved runs
// Ports: clock/reset (sync, active-high); missionary_in/cannibal_in = left-bank counts,
// finish_in = solver finish flag (001 solved); move_count/solve_count saturating counters,
// boat_side, done_pulse, sticky illegal with illegal_code (01 load, 10 unsafe, 11 sequence).
// Optional macro MC_OPTIMAL_CHECK_EN: reaching (0,0) in anything but 11 moves is an error.
module mc_move_validator (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] missionary_in,
  input  logic [1:0] cannibal_in,
  input  logic [2:0] finish_in,
  output logic [3:0] move_count,
  output logic [7:0] solve_count,
  output logic       boat_side,
  output logic       done_pulse,
  output logic       illegal,
  output logic [1:0] illegal_code
);
`ifdef MC_OPTIMAL_CHECK_EN
  localparam bit OptEn = 1'b1;
`else
  localparam bit OptEn = 1'b0;
`endif
  typedef enum logic [1:0] {WAIT_START, TRACK, DONE, ERROR} state_e;
  state_e state_q, state_d;
  logic [1:0] pm_q, pm_d, pc_q, pc_d, code_q, code_d;
  logic [3:0] move_q, move_d, move_inc;
  logic [7:0] solve_q, solve_d, solve_inc;
  logic boat_q, boat_d, done_q, done_d, ill_q, ill_d;
  logic signed [2:0] dm, dc;
  logic [3:0] sum;
  logic start, stall, is_zero, bad_load, unsafe, seq_bad, not_opt;
  always_comb begin
    // 3-bit signed differences so a 2-bit underflow shows up as a negative value
    dm = boat_q ? $signed({1'b0, missionary_in}) - $signed({1'b0, pm_q})
                : $signed({1'b0, pm_q}) - $signed({1'b0, missionary_in});
    dc = boat_q ? $signed({1'b0, cannibal_in}) - $signed({1'b0, pc_q})
                : $signed({1'b0, pc_q}) - $signed({1'b0, cannibal_in});
    sum = {dm[2], dm} + {dc[2], dc};
    move_inc = (move_q == 4'd15) ? 4'd15 : move_q + 4'd1;
    solve_inc = (solve_q == 8'd255) ? 8'd255 : solve_q + 8'd1;
    is_zero = (missionary_in == 2'd0) && (cannibal_in == 2'd0);
    start = (missionary_in == 2'd3) && (cannibal_in == 2'd3) && (finish_in == 3'b000);
    stall = (missionary_in == pm_q) && (cannibal_in == pc_q) && (finish_in == 3'b000);
    bad_load = dm[2] || dc[2] || (sum == 4'd0) || (sum > 4'd2);
    // right bank (3-m,3-c): 3-m>0 <=> m<3, and 3-m<3-c <=> m>c
    unsafe = ((missionary_in != 2'd0) && (missionary_in < cannibal_in)) ||
             ((missionary_in != 2'd3) && (missionary_in > cannibal_in));
    seq_bad = !(is_zero ? (finish_in == 3'b001) : (finish_in == 3'b000));
    not_opt = OptEn && is_zero && (move_inc != 4'd11);
  end
  always_comb begin
    state_d = state_q;
    pm_d = pm_q;
    pc_d = pc_q;
    move_d = move_q;
    solve_d = solve_q;
    boat_d = boat_q;
    done_d = 1'b0;
    ill_d = ill_q;
    code_d = code_q;
    case (state_q)
      WAIT_START, DONE: begin
        if (start) begin
          state_d = TRACK;
          pm_d = 2'd3;
          pc_d = 2'd3;
          move_d = 4'd0;
          boat_d = 1'b0;
        end else if (state_q == DONE && seq_bad) begin
          state_d = ERROR;
          ill_d = 1'b1;
          code_d = 2'b11;
        end
      end
      TRACK: begin
        if (!stall) begin
          if (bad_load || unsafe || seq_bad || not_opt) begin
            state_d = ERROR;
            ill_d = 1'b1;
            code_d = bad_load ? 2'b01 : unsafe ? 2'b10 : 2'b11;
          end else begin
            move_d = move_inc;
            boat_d = ~boat_q;
            pm_d = missionary_in;
            pc_d = cannibal_in;
            state_d = is_zero ? DONE : TRACK;
            done_d = is_zero;
            solve_d = is_zero ? solve_inc : solve_q;
          end
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= WAIT_START;
      pm_q <= 2'd3;
      pc_q <= 2'd3;
      move_q <= 4'd0;
      solve_q <= 8'd0;
      boat_q <= 1'b0;
      done_q <= 1'b0;
      ill_q <= 1'b0;
      code_q <= 2'b00;
    end else begin
      state_q <= state_d;
      pm_q <= pm_d;
      pc_q <= pc_d;
      move_q <= move_d;
      solve_q <= solve_d;
      boat_q <= boat_d;
      done_q <= done_d;
      ill_q <= ill_d;
      code_q <= code_d;
    end
  end
  assign move_count = move_q;
  assign solve_count = solve_q;
  assign boat_side = boat_q;
  assign done_pulse = done_q;
  assign illegal = ill_q;
  assign illegal_code = code_q;
endmodule
